map_draw_scheduler: RTL and testbench

MAP_DRAW_SCHEDULER -- requirements
Module: map_draw_scheduler

---
 rtl/map_draw_scheduler.sv | 139 +++++++++++++
 tb/tb_map_draw_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_draw_scheduler.sv
// Walks a MAP_W x MAP_H tile map, fetches each tile id and hands one draw job at a time to a
// tile drawer. Optional macro MAP_SCHED_SKIP_EMPTY_EN skips tiles whose id is 8'h00.
module map_draw_scheduler #(
  parameter int unsigned MAP_W      = 10,
  parameter int unsigned MAP_H      = 7,
  parameter int unsigned TILE_PX    = 16,
  parameter int unsigned TILE_WORDS = 256,
  parameter logic [15:0] TILE_BASE  = 16'h0000,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  map_data,
  input  logic        drawer_done,
  output logic [7:0]  map_addr,
  output logic [15:0] tile_address,
  output logic [7:0]  x_pos,
  output logic [7:0]  y_pos,
  output logic        draw,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [3:0] ColLast = 4'(MAP_W - 1);
  localparam logic [3:0] RowLast = 4'(MAP_H - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWaitId, StIssue, StWaitDone, StAdvance, StFrameDone
  } state_e;

  state_e          state_q;
  logic [3:0]      col_q, row_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      map_addr_q, x_q, y_q;
  logic [15:0]     tile_addr_q;
  logic            draw_q, busy_q, frame_done_q, timeout_q;
  logic            skip_tile;

`ifdef MAP_SCHED_SKIP_EMPTY_EN
  assign skip_tile = (map_data == 8'h00);
`else
  assign skip_tile = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      map_addr_q   <= '0;
      tile_addr_q  <= '0;
      x_q          <= '0;
      y_q          <= '0;
      draw_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      draw_q       <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFetch;
            col_q      <= '0;
            row_q      <= '0;
            map_addr_q <= '0;
            busy_q     <= 1'b1;
            timeout_q  <= 1'b0;
          end
        end
        StFetch: state_q <= StWaitId;
        // map_data answers the address presented during FETCH
        StWaitId: begin
          if (skip_tile) begin
            state_q <= StAdvance;
          end else begin
            state_q     <= StIssue;
            draw_q      <= 1'b1;
            tile_addr_q <= TILE_BASE + 16'(map_data * TILE_WORDS);
            x_q         <= 8'(col_q * TILE_PX);
            y_q         <= 8'(row_q * TILE_PX);
          end
        end
        StIssue: begin
          state_q <= StWaitDone;
          cnt_q   <= '0;
        end
        StWaitDone: begin
          if (drawer_done) begin
            state_q <= StAdvance;
          end else if (cnt_q == CntLast) begin
            state_q   <= StAdvance;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAdvance: begin
          if (col_q == ColLast) begin
            col_q <= '0;
            if (row_q == RowLast) begin
              state_q      <= StFrameDone;
              frame_done_q <= 1'b1;
            end else begin
              row_q      <= row_q + 4'd1;
              map_addr_q <= 8'((row_q + 4'd1) * MAP_W);
              state_q    <= StFetch;
            end
          end else begin
            col_q      <= col_q + 4'd1;
            map_addr_q <= map_addr_q + 8'd1;
            state_q    <= StFetch;
          end
        end
        StFrameDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign map_addr     = map_addr_q;
  assign tile_address = tile_addr_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign draw         = draw_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_map_draw_scheduler.sv
// Bench for map_draw_scheduler: a 2x2 instance for the scenario tests and a default 10x7
// instance for the full-frame walk, both checked against a list-of-tiles reference model.
module tb_map_draw_scheduler;

  localparam int SW = 2, SH = 2, BW = 10, BH = 7, TPX = 16, TW = 256, TBASE = 0;

  logic clk = 1'b0, resetn = 1'b0;

  logic start_s = 1'b0, drawer_done_s = 1'b0;
  logic [7:0] map_data_s = 8'h00;
  logic [7:0] map_addr_s, x_pos_s, y_pos_s;
  logic [15:0] tile_address_s;
  logic draw_s, busy_s, frame_done_s, timeout_err_s;

  logic start_b = 1'b0, drawer_done_b = 1'b0;
  logic [7:0] map_data_b = 8'h00;
  logic [7:0] map_addr_b, x_pos_b, y_pos_b;
  logic [15:0] tile_address_b;
  logic draw_b, busy_b, frame_done_b, timeout_err_b;

  logic [7:0] mem_s [SW*SH];
  logic [7:0] mem_b [BW*BH];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  // synchronous map RAMs: data appears one cycle after the address
  always @(posedge clk) map_data_s <= mem_s[map_addr_s[1:0]];
  always @(posedge clk) map_data_b <= (int'(map_addr_b) < BW*BH) ? mem_b[int'(map_addr_b)] : 8'h00;

  map_draw_scheduler #(.MAP_W(SW), .MAP_H(SH)) dut_s (
    .clk(clk), .resetn(resetn), .start(start_s), .map_data(map_data_s),
    .drawer_done(drawer_done_s), .map_addr(map_addr_s), .tile_address(tile_address_s),
    .x_pos(x_pos_s), .y_pos(y_pos_s), .draw(draw_s), .busy(busy_s),
    .frame_done(frame_done_s), .timeout_err(timeout_err_s)
  );

  map_draw_scheduler dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .map_data(map_data_b),
    .drawer_done(drawer_done_b), .map_addr(map_addr_b), .tile_address(tile_address_b),
    .x_pos(x_pos_b), .y_pos(y_pos_b), .draw(draw_b), .busy(busy_b),
    .frame_done(frame_done_b), .timeout_err(timeout_err_b)
  );

  function automatic bit skipped(input logic [7:0] id);
`ifdef MAP_SCHED_SKIP_EMPTY_EN
    return id == 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one frame on the 2x2 instance. Model: tiles are drawn in index order, each at
  // (i%W*TPX, i/W*TPX) with ROM base TBASE + id*TW; empty ids vanish when skipping is built in.
  task automatic run_frame_s(input int delay, input int hang_idx, input int restart_edge,
                             input bit spur, output int n_draws, output int n_frames,
                             output int to_edges);
    int exp_q[$];
    int exp_cnt, edge_n, cd, hang_edge, idx;
    bit hung, prev_draw, first, dd;
    logic [15:0] held_a;
    logic [7:0] held_x, held_y;
    for (int i = 0; i < SW*SH; i++) if (!skipped(mem_s[i])) exp_q.push_back(i);
    exp_cnt = exp_q.size();
    n_draws = 0; n_frames = 0; to_edges = -1; cd = 0; hung = 0; hang_edge = 0;
    prev_draw = 0; first = 1; edge_n = 0;
    held_a = '0; held_x = '0; held_y = '0;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    checks++;
    if (busy_s !== 1'b1 || timeout_err_s !== 1'b0)
      $display("FAIL start_accept: busy=%b timeout_err=%b, expected busy=1 timeout_err=0",
               busy_s, timeout_err_s);
    if (busy_s !== 1'b1 || timeout_err_s !== 1'b0) failures++;
    while (n_frames == 0 && edge_n < 3000) begin
      @(posedge clk); #1;
      edge_n++;
      dd = 1'b0;
      if (hung && timeout_err_s === 1'b1) begin
        hung = 0;
        to_edges = edge_n - hang_edge;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) dd = 1'b1;
      end else if (!hung && spur && $urandom_range(0, 3) == 0) begin
        dd = 1'b1;
      end
      if (cd > 0 || hung) begin
        checks++;
        if ({tile_address_s, x_pos_s, y_pos_s} !== {held_a, held_x, held_y}) begin
          failures++;
          $display("FAIL hold_stable: got %h/%0d/%0d, expected %h/%0d/%0d", tile_address_s,
                   x_pos_s, y_pos_s, held_a, held_x, held_y);
        end
      end
      if (draw_s === 1'b1) begin
        checks++;
        if (prev_draw) begin
          failures++;
          $display("FAIL draw_width: draw high on consecutive cycles, expected one-cycle pulse");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_draw: draw at map_addr %0d, expected no more draws", map_addr_s);
        end else begin
          idx = exp_q.pop_front();
          if (first && idx == 0) begin
            checks++;
            if (edge_n != 2) begin
              failures++;
              $display("FAIL start_latency: draw %0d edges after start edge, expected 2", edge_n);
            end
          end
          if (map_addr_s !== 8'(idx) || tile_address_s !== 16'(TBASE + mem_s[idx] * TW) ||
              x_pos_s !== 8'((idx % SW) * TPX) || y_pos_s !== 8'((idx / SW) * TPX)) begin
            failures++;
            $display("FAIL tile_%0d: got addr=%0d rom=%h x=%0d y=%0d, expected %0d %h %0d %0d",
                     idx, map_addr_s, tile_address_s, x_pos_s, y_pos_s, idx,
                     16'(TBASE + mem_s[idx] * TW), (idx % SW) * TPX, (idx / SW) * TPX);
          end
        end
        first = 0;
        n_draws++;
        held_a = tile_address_s; held_x = x_pos_s; held_y = y_pos_s;
        if (int'(map_addr_s) == hang_idx) begin
          hung = 1;
          hang_edge = edge_n;
        end else begin
          cd = (delay > 0) ? delay : int'($urandom_range(1, 8));
        end
        dd = 1'b0;
      end
      prev_draw = (draw_s === 1'b1);
      if (frame_done_s === 1'b1) n_frames++;
      start_s = (edge_n == restart_edge);
      drawer_done_s = dd;
    end
    start_s = 1'b0;
    drawer_done_s = 1'b0;
    checks++;
    if (n_frames != 1) begin
      failures++;
      $display("FAIL frame_done: saw %0d pulses in %0d cycles, expected 1", n_frames, edge_n);
    end
    checks++;
    if (n_draws != exp_cnt) begin
      failures++;
      $display("FAIL draw_count: got %0d, expected %0d", n_draws, exp_cnt);
    end
    checks++;
    if (timeout_err_s !== (hang_idx >= 0)) begin
      failures++;
      $display("FAIL timeout_flag: got %b, expected %b", timeout_err_s, hang_idx >= 0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_s !== 1'b0 || frame_done_s !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_frame: busy=%b frame_done=%b, expected 0 0", busy_s, frame_done_s);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if ({map_addr_s, tile_address_s, x_pos_s, y_pos_s, draw_s, busy_s, frame_done_s,
         timeout_err_s} !== '0) begin
      failures++;
      $display("FAIL reset_small: got %h %h %h %h %b%b%b%b, expected all zero", map_addr_s,
               tile_address_s, x_pos_s, y_pos_s, draw_s, busy_s, frame_done_s, timeout_err_s);
    end
    checks++;
    if ({map_addr_b, tile_address_b, x_pos_b, y_pos_b, draw_b, busy_b, frame_done_b,
         timeout_err_b} !== '0) begin
      failures++;
      $display("FAIL reset_big: got %h %h %h %h %b%b%b%b, expected all zero", map_addr_b,
               tile_address_b, x_pos_b, y_pos_b, draw_b, busy_b, frame_done_b, timeout_err_b);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_map();
    int nd, nf, te;
    mem_s[0] = 8'd3; mem_s[1] = 8'd0; mem_s[2] = 8'd1; mem_s[3] = 8'd2;
    run_frame_s(5, -1, -1, 1'b0, nd, nf, te);
    checks++;
`ifdef MAP_SCHED_SKIP_EMPTY_EN
    if (nd != 3) begin
      failures++;
      $display("FAIL spec_map_draws: got %0d, expected 3", nd);
    end
`else
    if (nd != 4) begin
      failures++;
      $display("FAIL spec_map_draws: got %0d, expected 4", nd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int nd, nf, te, extra;
    for (int i = 0; i < SW*SH; i++) mem_s[i] = 8'($urandom_range(1, 255));
    run_frame_s(4, -1, 5, 1'b0, nd, nf, te);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (draw_s !== 1'b0 || busy_s !== 1'b0 || frame_done_s !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL restart_ignored: %0d active cycles after frame, expected 0", extra);
    end
  endtask

  task automatic test_timeout();
    int nd, nf, te;
    for (int i = 0; i < SW*SH; i++) mem_s[i] = 8'($urandom_range(1, 255));
    run_frame_s(3, 1, -1, 1'b0, nd, nf, te);
    checks++;
    if (te != 1024) begin
      failures++;
      $display("FAIL timeout_delay: timeout_err %0d cycles after draw, expected 1024", te);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (timeout_err_s !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got %b, expected 1", timeout_err_s);
    end
    run_frame_s(2, -1, -1, 1'b0, nd, nf, te);
  endtask

  task automatic test_random_frames();
    int nd, nf, te;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < SW*SH; i++)
        mem_s[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_frame_s(0, -1, -1, 1'b1, nd, nf, te);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nd, nf, te, n, seen_fd, active;
    for (int i = 0; i < SW*SH; i++) mem_s[i] = 8'($urandom_range(1, 255));
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 0;
    while (draw_s !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (draw_s !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_draw: no draw within 20 cycles, expected one");
    end
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({map_addr_s, tile_address_s, x_pos_s, y_pos_s, draw_s, busy_s, frame_done_s,
         timeout_err_s} !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h %h %h %h %b%b%b%b, expected all zero", map_addr_s,
               tile_address_s, x_pos_s, y_pos_s, draw_s, busy_s, frame_done_s, timeout_err_s);
    end
    seen_fd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (frame_done_s !== 1'b0) seen_fd++;
    end
    @(negedge clk);
    resetn = 1'b1;
    active = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (frame_done_s !== 1'b0) seen_fd++;
      if (busy_s !== 1'b0 || draw_s !== 1'b0) active++;
    end
    checks++;
    if (seen_fd != 0 || active != 0) begin
      failures++;
      $display("FAIL reset_abandon: frame_done=%0d active=%0d, expected 0 0", seen_fd, active);
    end
    run_frame_s(0, -1, -1, 1'b0, nd, nf, te);
  endtask

  task automatic test_full_map();
    int exp_q[$];
    int exp_cnt, nd, nf, cd, idx, edge_n, last_addr, last_x, last_y;
    for (int i = 0; i < BW*BH; i++)
      mem_b[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    mem_b[BW*BH-1] = 8'($urandom_range(1, 255));
    for (int i = 0; i < BW*BH; i++) if (!skipped(mem_b[i])) exp_q.push_back(i);
    exp_cnt = exp_q.size();
    nd = 0; nf = 0; cd = 0; edge_n = 0; last_addr = -1; last_x = -1; last_y = -1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    while (nf == 0 && edge_n < 20000) begin
      @(posedge clk); #1;
      edge_n++;
      drawer_done_b = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) drawer_done_b = 1'b1;
      end
      if (draw_b === 1'b1) begin
        nd++;
        cd = $urandom_range(1, 3);
        last_addr = map_addr_b; last_x = x_pos_b; last_y = y_pos_b;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL full_extra_draw: draw at map_addr %0d, expected none", map_addr_b);
        end else begin
          idx = exp_q.pop_front();
          if (map_addr_b !== 8'(idx) || tile_address_b !== 16'(TBASE + mem_b[idx] * TW) ||
              x_pos_b !== 8'((idx % BW) * TPX) || y_pos_b !== 8'((idx / BW) * TPX)) begin
            failures++;
            $display("FAIL full_tile_%0d: got %0d %h %0d %0d, expected %0d %h %0d %0d", idx,
                     map_addr_b, tile_address_b, x_pos_b, y_pos_b, idx,
                     16'(TBASE + mem_b[idx] * TW), (idx % BW) * TPX, (idx / BW) * TPX);
          end
        end
      end
      if (frame_done_b === 1'b1) nf++;
    end
    drawer_done_b = 1'b0;
    checks++;
    if (nf != 1 || nd != exp_cnt) begin
      failures++;
      $display("FAIL full_frame: frames=%0d draws=%0d, expected 1 and %0d", nf, nd, exp_cnt);
    end
`ifndef MAP_SCHED_SKIP_EMPTY_EN
    checks++;
    if (nd != 70) begin
      failures++;
      $display("FAIL full_70: got %0d draws, expected 70", nd);
    end
`endif
    checks++;
    if (last_addr != 69 || last_x != 144 || last_y != 96) begin
      failures++;
      $display("FAIL full_last: got addr=%0d x=%0d y=%0d, expected 69 144 96", last_addr,
               last_x, last_y);
    end
  endtask

  initial begin
    test_reset();
    test_spec_map();
    test_back_to_back();
    test_timeout();
    test_random_frames();
    test_reset_mid_frame();
    test_full_map();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
